// File: rtl/cyc_delay_pkg.sv
// rtl/cyc_delay_pkg.sv - shared types, limits and helpers for the cycle-delay responder
package cyc_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } cdr_state_e;

  localparam int MAX_LATENCY = 8;
  localparam int MAX_CHECK_W = 64;

  // Callers zero-extend narrower buses; leading zeros do not change the result.
  function automatic logic is_onehot0(input logic [MAX_CHECK_W-1:0] x);
    return (x & (x - 64'd1)) == '0;
  endfunction

endpackage

// File: rtl/delay_pipe.sv
// rtl/delay_pipe.sv - DEPTH-stage shift register of {data, valid}, no stall
module delay_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             v,
  output logic [WIDTH-1:0] last_data,
  output logic             last_v,
  output logic             any_v
);

  logic [WIDTH-1:0] sd [DEPTH];
  logic [DEPTH-1:0] sv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sd[k] <= '0;
      sv <= '0;
    end else begin
      sd[0] <= data;
      sv[0] <= v;
      for (int k = 1; k < DEPTH; k++) begin
        sd[k] <= sd[k-1];
        sv[k] <= sv[k-1];
      end
    end
  end

  assign last_data = sd[DEPTH-1];
  assign last_v    = sv[DEPTH-1];
  assign any_v     = |sv;

endmodule

// File: rtl/cyc_delay_responder.sv
// rtl/cyc_delay_responder.sv - returns the driven bus after LATENCY edges with change count and one-hot check
module cyc_delay_responder
  import cyc_delay_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int INVERT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             onehot_err_o,
  output logic [CNT_W-1:0] chg_cnt_o,
  output logic [1:0]       state_o
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("cyc_delay_responder: LATENCY must be in 1..%0d", MAX_LATENCY);
  end
  if (WIDTH > MAX_CHECK_W) begin : g_bad_width
    $error("cyc_delay_responder: WIDTH must not exceed %0d", MAX_CHECK_W);
  end

  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] last_data;
  logic             last_v;
  logic             pipe_any;
  cdr_state_e       state, state_nxt;

  assign in_data = (INVERT != 0) ? ~d_i : d_i;

  // The q_o/valid_o register is the final stage, so only LATENCY-1 stages live in the pipe.
  if (LATENCY == 1) begin : g_direct
    assign last_data = in_data;
    assign last_v    = en_i;
    assign pipe_any  = 1'b0;
  end else begin : g_pipe
    delay_pipe #(
      .WIDTH(WIDTH),
      .DEPTH(LATENCY - 1)
    ) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .data     (in_data),
      .v        (en_i),
      .last_data(last_data),
      .last_v   (last_v),
      .any_v    (pipe_any)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o          <= '0;
      valid_o      <= 1'b0;
      chg_cnt_o    <= '0;
      onehot_err_o <= 1'b0;
      state        <= IDLE;
    end else begin
      valid_o <= last_v;
      state   <= state_nxt;
      if (last_v) begin
        q_o <= last_data;
        if (last_data != q_o && chg_cnt_o != '1) chg_cnt_o <= chg_cnt_o + CNT_W'(1);
      end
      // Set has priority over clear.
      if (en_i && !is_onehot0(MAX_CHECK_W'(d_i))) onehot_err_o <= 1'b1;
      else if (clr_err_i)                          onehot_err_o <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en_i) state_nxt = (LATENCY == 1) ? RUN : FILL;
      FILL:  if (last_v) state_nxt = RUN;
      RUN:   if (!en_i) state_nxt = (LATENCY == 1) ? IDLE : DRAIN;
      DRAIN: begin
        if (en_i)                      state_nxt = RUN;
        else if (!pipe_any && !valid_o) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_cyc_delay_responder.sv
// tb/tb_cyc_delay_responder.sv - scoreboard bench over five parameterisations sharing one stimulus bus
module tb_cyc_delay_responder;

  localparam int N_DUT = 5;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q [N_DUT][$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] d;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic [7:0]  q_a     [N_DUT];
  logic        valid_a [N_DUT];
  logic        err_a   [N_DUT];
  logic [1:0]  st_a    [N_DUT];
  logic [15:0] cnt_a   [N_DUT];

  int lat_of [N_DUT] = '{2, 1, 4, 8, 2};

  // Walking one: 1<<8 truncates to 0x00 on an 8-bit bus.
  logic [7:0] walk_d [10] = '{8'h00, 8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
  logic [7:0] walk_q [10] = '{8'hFF, 8'hFF, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFF};

  logic       bub_en [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] bub_d  [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [7:0] bub_x  [4] = '{8'hFE, 8'h00, 8'hFB, 8'h00};
  logic [7:0] bub_q  [4] = '{8'h00, 8'hFE, 8'hFE, 8'hFB};
  logic       bub_v  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int L  = (g == 1) ? 1 : (g == 2) ? 4 : (g == 3) ? 8 : 2;
    localparam int CW = (g == 4) ? 4 : 16;
    logic [CW-1:0] cnt;

    cyc_delay_responder #(
      .WIDTH(8), .LATENCY(L), .INVERT(1), .CNT_W(CW)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en),
      .d_i         (d),
      .clr_err_i   (clr),
      .q_o         (q_a[g]),
      .valid_o     (valid_a[g]),
      .onehot_err_o(err_a[g]),
      .chg_cnt_o   (cnt),
      .state_o     (st_a[g])
    );
    assign cnt_a[g] = 16'(cnt);

    always @(posedge clk) begin
      exp_t e;
      #6;
      if (rst_n && valid_a[g]) begin
        if (exp_q[g].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut%0d unexpected valid: q=0x%0h, expected no output", g, q_a[g]);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("dut%0d q_o", g), int'(q_a[g]), int'(e.data));
          check($sformatf("dut%0d latency", g), cyc - e.cyc, L - 1);
        end
      end
    end
  end

  task automatic step(input logic s_en, input logic [7:0] s_d, input logic s_clr, input logic [7:0] s_q);
    en  = s_en;
    d   = s_d;
    clr = s_clr;
    if (s_en) for (int i = 0; i < N_DUT; i++) exp_q[i].push_back('{s_q, cyc + 1});
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic flush();
    for (int i = 0; i < N_DUT; i++) exp_q[i].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int exp_state(input int lat, input int t);
    if (lat == 1) return (t == 0) ? 2 : 0;
    if (t < lat - 1) return 1;
    if (t == lat - 1) return 2;
    if (t == lat) return 3;
    return 0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    d     = 8'h00;
    clr   = 1'b0;
    #3;
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("reset dut%0d q", i), int'(q_a[i]), 0);
      check($sformatf("reset dut%0d valid", i), int'(valid_a[i]), 0);
      check($sformatf("reset dut%0d err", i), int'(err_a[i]), 0);
      check($sformatf("reset dut%0d cnt", i), int'(cnt_a[i]), 0);
      check($sformatf("reset dut%0d state", i), int'(st_a[i]), 0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b1, walk_d[i], 1'b0, walk_q[i]);
    idle(10);
    check("walk cnt dut0", int'(cnt_a[0]), 9);
    check("walk cnt dut3", int'(cnt_a[3]), 9);
    check("walk err dut0", int'(err_a[0]), 0);
    for (int i = 0; i < N_DUT; i++) check($sformatf("walk idle dut%0d", i), int'(st_a[i]), 0);

    step(1'b1, 8'h5A, 1'b0, 8'hA5);
    for (int t = 0; t < 11; t++) begin
      for (int j = 1; j <= 3; j++) begin
        check($sformatf("sweep L%0d t%0d state", lat_of[j], t), int'(st_a[j]), exp_state(lat_of[j], t));
        check($sformatf("sweep L%0d t%0d valid", lat_of[j], t), int'(valid_a[j]), (t == lat_of[j] - 1) ? 1 : 0);
      end
      step(1'b0, 8'h00, 1'b0, 8'h00);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(bub_en[i], bub_d[i], 1'b0, bub_x[i]);
      check($sformatf("bubble %0d q", i), int'(q_a[0]), int'(bub_q[i]));
      check($sformatf("bubble %0d valid", i), int'(valid_a[0]), int'(bub_v[i]));
    end
    idle(10);
    check("bubble cnt", int'(cnt_a[0]), 2);

    step(1'b1, 8'h03, 1'b0, 8'hFC);
    check("onehot 0x03 en set", int'(err_a[0]), 1);
    step(1'b0, 8'h00, 1'b1, 8'h00);
    check("onehot clear", int'(err_a[0]), 0);
    step(1'b0, 8'h03, 1'b0, 8'h00);
    check("onehot 0x03 no en", int'(err_a[0]), 0);
    step(1'b1, 8'h06, 1'b1, 8'hF9);
    check("onehot set wins", int'(err_a[0]), 1);
    check("onehot set wins dut1", int'(err_a[1]), 1);
    step(1'b0, 8'h00, 1'b1, 8'h00);
    check("onehot clear again", int'(err_a[0]), 0);
    step(1'b1, 8'h00, 1'b0, 8'hFF);
    check("onehot zero legal", int'(err_a[0]), 0);
    step(1'b1, 8'h80, 1'b0, 8'h7F);
    check("onehot single legal", int'(err_a[0]), 0);
    idle(10);

    for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 8'hEF - 8'(i));
    rst_n = 1'b0;
    flush();
    #1;
    check("midreset dut2 q", int'(q_a[2]), 0);
    check("midreset dut2 valid", int'(valid_a[2]), 0);
    check("midreset dut2 cnt", int'(cnt_a[2]), 0);
    check("midreset dut2 state", int'(st_a[2]), 0);
    check("midreset dut3 valid", int'(valid_a[3]), 0);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step(1'b1, 8'h30 + 8'(t), 1'b0, 8'hCF - 8'(t));
      check($sformatf("post-reset t%0d valid", t), int'(valid_a[2]), (t >= 3) ? 1 : 0);
    end
    idle(10);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1'b1, 8'h01, 1'b0, 8'hFE);
      else            step(1'b1, 8'h02, 1'b0, 8'hFD);
      if (i == 17) check("sat cnt reached", int'(cnt_a[4]), 15);
    end
    idle(10);
    check("sat cnt sticks", int'(cnt_a[4]), 15);
    check("wide cnt 20 changes", int'(cnt_a[0]), 20);

    for (int i = 0; i < N_DUT; i++) check($sformatf("dut%0d leftover expected", i), exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
